// File: rtl/count_stream_monitor_pkg.sv
// Shared types and default sizing for the count stream monitor.
package count_stream_monitor_pkg;

    // Default geometry, matching the 4-bit enable counter it checks.
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_LOCK_N = 4;
    localparam int DEF_STAT_W = 8;

    // EMPTY: no prior sample. ACQ: counting good steps. LOCKED: reporting.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    // Width of the good-step counter; at least one bit even for LOCK_N=1.
    function automatic int good_cnt_width(input int lock_n);
        return (lock_n > 1) ? $clog2(lock_n) : 1;
    endfunction

endpackage

// File: rtl/count_stream_monitor_if.sv
// Sample/status bundle between a count source and the monitor.
interface count_stream_monitor_if #(
    parameter int WIDTH  = 4,
    parameter int STAT_W = 8
);
    logic              clear;
    logic [WIDTH-1:0]  count_in;
    logic              en_in;
    logic              locked;
    logic              mismatch;
    logic              wrap_pulse;
    logic [STAT_W-1:0] err_cnt;
    logic [STAT_W-1:0] wrap_cnt;
    logic [WIDTH-1:0]  expected;

    // The side that feeds samples and reads status.
    modport master (
        output clear, count_in, en_in,
        input  locked, mismatch, wrap_pulse, err_cnt, wrap_cnt, expected
    );

    // The monitor itself.
    modport slave (
        input  clear, count_in, en_in,
        output locked, mismatch, wrap_pulse, err_cnt, wrap_cnt, expected
    );
endinterface

// File: rtl/count_stream_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over inc.
module sat_counter #(
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inc,
    output logic [STAT_W-1:0] cnt
);
    logic [STAT_W-1:0] cnt_reg;

    // Count up on inc, hold at all-ones, zero on reset or clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {STAT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + STAT_W'(1);
        end
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/count_stream_monitor.sv
// Checks that each sampled count equals previous count + previous enable
// (mod 2^WIDTH); locks after LOCK_N good steps, then reports mismatches
// and wraps as one-cycle pulses plus saturating counters.
module count_stream_monitor
    import count_stream_monitor_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LOCK_N = DEF_LOCK_N,
    parameter int STAT_W = DEF_STAT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    count_stream_monitor_if.slave  mon
);
    localparam int GC_W = good_cnt_width(LOCK_N);
    localparam logic [GC_W-1:0] LAST_GOOD = GC_W'(LOCK_N - 1);

    mon_state_t       state_reg;
    logic [WIDTH-1:0] prev_count_reg;
    logic             prev_en_reg;
    logic [GC_W-1:0]  good_cnt_reg;
    logic             mismatch_reg;
    logic             wrap_pulse_reg;

    logic [WIDTH-1:0] expected_next;
    logic             good;
    logic             wrap_event;
    logic             err_inc;
    logic             wrap_inc;

    // Truncating add, so all-ones plus one predicts zero.
    assign expected_next = prev_count_reg + WIDTH'(prev_en_reg);
    assign good          = (mon.count_in == expected_next);
    assign wrap_event    = good && prev_en_reg && (prev_count_reg == {WIDTH{1'b1}});
    assign err_inc       = (state_reg == LOCKED) && !good;
    assign wrap_inc      = (state_reg == LOCKED) && wrap_event;

    // Lock FSM plus sample history; history always resyncs to the input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= EMPTY;
            prev_count_reg <= '0;
            prev_en_reg    <= 1'b0;
            good_cnt_reg   <= '0;
            mismatch_reg   <= 1'b0;
            wrap_pulse_reg <= 1'b0;
        end else begin
            prev_count_reg <= mon.count_in;
            prev_en_reg    <= mon.en_in;
            mismatch_reg   <= 1'b0;
            wrap_pulse_reg <= 1'b0;
            case (state_reg)
                EMPTY: begin
                    // First sample only seeds the history.
                    state_reg    <= ACQ;
                    good_cnt_reg <= '0;
                end
                ACQ: begin
                    if (!good) begin
                        good_cnt_reg <= '0;
                    end else if (good_cnt_reg == LAST_GOOD) begin
                        state_reg    <= LOCKED;
                        good_cnt_reg <= '0;
                    end else begin
                        good_cnt_reg <= good_cnt_reg + GC_W'(1);
                    end
                end
                LOCKED: begin
                    if (!good) begin
                        mismatch_reg <= 1'b1;
                        state_reg    <= ACQ;
                        good_cnt_reg <= '0;
                    end else if (wrap_event) begin
                        wrap_pulse_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= EMPTY;
                    good_cnt_reg <= '0;
                end
            endcase
        end
    end

    sat_counter #(.STAT_W(STAT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mon.clear),
        .inc   (err_inc),
        .cnt   (mon.err_cnt)
    );

    sat_counter #(.STAT_W(STAT_W)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mon.clear),
        .inc   (wrap_inc),
        .cnt   (mon.wrap_cnt)
    );

    assign mon.locked     = (state_reg == LOCKED);
    assign mon.mismatch   = mismatch_reg;
    assign mon.wrap_pulse = wrap_pulse_reg;
    assign mon.expected   = expected_next;
endmodule
